// File: rtl/sp_ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous-read RAM.
// Optionally zero-fills the RAM after reset, then grants one requester per cycle.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_INIT | zero-filling the RAM, one address per cycle
// ST_RUN  | arbitrating between requesters A and B
module sp_ram_arbiter #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int CLEAR_ON_INIT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  init_done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [0:0] ST_RESET = (CLEAR_ON_INIT != 0) ? ST_INIT : ST_RUN;

  // One extra counter bit so the last address is reached without wrapping to 0.
  localparam logic [ADDR_WIDTH:0] FILL_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

  logic [0:0]          state;
  logic [ADDR_WIDTH:0] fill_cnt;
  logic                favour_b;
  logic                run;
  logic                fill_last;

  assign run       = (state == ST_RUN);
  assign fill_last = (fill_cnt == FILL_LAST);

  assign a_gnt = run & a_req & (~b_req | ~favour_b);
  assign b_gnt = run & b_req & (~a_req |  favour_b);

  assign a_rdata = ram_dout;
  assign b_rdata = ram_dout;

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (!run) begin
      ram_we   = 1'b1;
      ram_addr = fill_cnt[ADDR_WIDTH-1:0];
    end else if (a_gnt) begin
      ram_we   = a_we;
      ram_addr = a_addr;
      ram_din  = a_wdata;
    end else if (b_gnt) begin
      ram_we   = b_we;
      ram_addr = b_addr;
      ram_din  = b_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RESET;
      fill_cnt  <= '0;
      favour_b  <= 1'b0;
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
      init_done <= 1'b0;
    end else begin
      a_rvalid  <= a_gnt & ~a_we;
      b_rvalid  <= b_gnt & ~b_we;
      init_done <= run | fill_last;
      if (a_gnt) begin
        favour_b <= 1'b1;
      end else if (b_gnt) begin
        favour_b <= 1'b0;
      end
      if (!run) begin
        fill_cnt <= fill_cnt + 1'b1;
        if (fill_last) begin
          state <= ST_RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter: one instance with the zero-fill enabled,
// one without, each wired to a simple synchronous-read RAM model.
module tb_sp_ram_arbiter;

  logic        clk;
  logic        rst;
  logic        a_req, a_we, a_gnt, a_rvalid;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic        b_req, b_we, b_gnt, b_rvalid;
  logic [7:0]  b_addr;
  logic [31:0] b_wdata, b_rdata;
  logic        ram_we, init_done;
  logic [7:0]  ram_addr;
  logic [31:0] ram_din, ram_dout;

  logic        z_rst;
  logic        z_a_req, z_a_we, z_a_gnt, z_a_rvalid;
  logic [7:0]  z_a_addr;
  logic [31:0] z_a_wdata, z_a_rdata;
  logic        z_b_req, z_b_we, z_b_gnt, z_b_rvalid;
  logic [7:0]  z_b_addr;
  logic [31:0] z_b_wdata, z_b_rdata;
  logic        z_ram_we, z_init_done;
  logic [7:0]  z_ram_addr;
  logic [31:0] z_ram_din, z_ram_dout;

  logic [31:0] mem   [0:255];
  logic [31:0] z_mem [0:255];

  int n_asserts = 0;
  int n_fail    = 0;

  sp_ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .CLEAR_ON_INIT(1)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .init_done(init_done)
  );

  sp_ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .CLEAR_ON_INIT(0)) dut_nofill (
    .clk(clk), .rst(z_rst),
    .a_req(z_a_req), .a_we(z_a_we), .a_addr(z_a_addr), .a_wdata(z_a_wdata),
    .a_gnt(z_a_gnt), .a_rvalid(z_a_rvalid), .a_rdata(z_a_rdata),
    .b_req(z_b_req), .b_we(z_b_we), .b_addr(z_b_addr), .b_wdata(z_b_wdata),
    .b_gnt(z_b_gnt), .b_rvalid(z_b_rvalid), .b_rdata(z_b_rdata),
    .ram_we(z_ram_we), .ram_addr(z_ram_addr), .ram_din(z_ram_din), .ram_dout(z_ram_dout),
    .init_done(z_init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  always @(posedge clk) begin
    if (z_ram_we) z_mem[z_ram_addr] <= z_ram_din;
    z_ram_dout <= z_mem[z_ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expects the fill to start on the current cycle; returns just after the RUN edge.
  task automatic fill_check();
    for (int i = 0; i < 256; i++) begin
      #1;
      chk("fill_ctl", 32'(ram_we & ~a_gnt & ~b_gnt & ~init_done & (ram_din == 32'h0)), 32'd1);
      chk("fill_addr", 32'(ram_addr), 32'(i));
      cyc();
    end
  endtask

  initial begin
    rst = 1'b0;   z_rst = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h00; a_wdata = 32'h0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 8'h00; b_wdata = 32'h0;
    z_a_req = 1'b0; z_a_we = 1'b0; z_a_addr = 8'h00; z_a_wdata = 32'h0;
    z_b_req = 1'b0; z_b_we = 1'b0; z_b_addr = 8'h00; z_b_wdata = 32'h0;

    repeat (3) cyc();
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_b_rvalid", 32'(b_rvalid), 32'd0);
    chk("rst_a_gnt", 32'(a_gnt), 32'd0);

    rst = 1'b1;
    fill_check();
    chk("fill_init_done", 32'(init_done), 32'd1);

    // reads of 0, 17, 255 after the fill
    #1 chk("rd0_gnt", 32'(a_gnt), 32'd1);
    cyc();
    chk("rd0_rvalid", 32'(a_rvalid), 32'd1);
    chk("rd0_data", a_rdata, 32'h0);
    a_addr = 8'd17;
    #1 chk("rd17_gnt", 32'(a_gnt), 32'd1);
    cyc();
    chk("rd17_rvalid", 32'(a_rvalid), 32'd1);
    chk("rd17_data", a_rdata, 32'h0);
    a_addr = 8'd255;
    #1 chk("rd255_gnt", 32'(a_gnt), 32'd1);
    cyc();
    chk("rd255_rvalid", 32'(a_rvalid), 32'd1);
    chk("rd255_data", a_rdata, 32'h0);

    // write then read-after-write
    a_we = 1'b1; a_addr = 8'h10; a_wdata = 32'hDEADBEEF;
    #1;
    chk("wr_gnt", 32'(a_gnt), 32'd1);
    chk("wr_ram_we", 32'(ram_we), 32'd1);
    chk("wr_ram_addr", 32'(ram_addr), 32'h10);
    chk("wr_ram_din", ram_din, 32'hDEADBEEF);
    cyc();
    chk("wr_no_rvalid", 32'(a_rvalid), 32'd0);
    a_we = 1'b0;
    #1 chk("raw_gnt", 32'(a_gnt), 32'd1);
    cyc();
    chk("raw_rvalid", 32'(a_rvalid), 32'd1);
    chk("raw_data", a_rdata, 32'hDEADBEEF);
    chk("raw_b_rvalid", 32'(b_rvalid), 32'd0);

    // idle cycle in RUN
    a_req = 1'b0;
    #1;
    chk("idle_gnt", 32'({a_gnt, b_gnt}), 32'd0);
    chk("idle_ram", 32'({ram_we, ram_addr}), 32'd0);
    cyc();
    chk("rvalid_one_cycle", 32'(a_rvalid), 32'd0);

    // seed addresses 1 and 2 (A then B)
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'd1; a_wdata = 32'h11111111;
    #1 chk("seed_a_gnt", 32'(a_gnt), 32'd1);
    cyc();
    a_req = 1'b0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'd2; b_wdata = 32'h22222222;
    #1;
    chk("seed_b_gnt", 32'({a_gnt, b_gnt}), 32'b01);
    chk("seed_b_din", ram_din, 32'h22222222);
    cyc();

    // B alone three times
    b_we = 1'b0; b_addr = 8'h10;
    for (int k = 0; k < 3; k++) begin
      #1 chk("b_alone_gnt", 32'({a_gnt, b_gnt}), 32'b01);
      cyc();
      chk("b_alone_rvalid", 32'({a_rvalid, b_rvalid}), 32'b01);
      chk("b_alone_data", b_rdata, 32'hDEADBEEF);
    end

    // contended: A, B, A, B, A, B
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'd1; b_addr = 8'd2;
    for (int k = 0; k < 6; k++) begin
      #1 chk("rr_gnt", 32'({a_gnt, b_gnt}), (k % 2 == 0) ? 32'b10 : 32'b01);
      cyc();
      chk("rr_rvalid", 32'({a_rvalid, b_rvalid}), (k % 2 == 0) ? 32'b10 : 32'b01);
      chk("rr_data", (k % 2 == 0) ? a_rdata : b_rdata,
          (k % 2 == 0) ? 32'h11111111 : 32'h22222222);
    end

    // reset right after a read accept
    b_req = 1'b0;
    #1 chk("prerst_gnt", 32'(a_gnt), 32'd1);
    cyc();
    chk("prerst_rvalid", 32'(a_rvalid), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_kill_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_kill_init_done", 32'(init_done), 32'd0);
    cyc();
    rst = 1'b1;
    fill_check();
    chk("refill_init_done", 32'(init_done), 32'd1);
    a_req = 1'b0;

    // instance without fill: write 0x1 to 0xFF on the first RUN cycle
    z_a_req = 1'b1; z_a_we = 1'b1; z_a_addr = 8'hFF; z_a_wdata = 32'h1;
    z_rst = 1'b1;
    #1;
    chk("nf_wr_gnt", 32'(z_a_gnt), 32'd1);
    chk("nf_ram_addr", 32'({z_ram_we, z_ram_addr}), 32'h1FF);
    chk("nf_init_done_0", 32'(z_init_done), 32'd0);
    cyc();
    chk("nf_init_done_1", 32'(z_init_done), 32'd1);
    z_a_we = 1'b0;
    #1 chk("nf_rd_gnt", 32'(z_a_gnt), 32'd1);
    cyc();
    chk("nf_rd_rvalid", 32'(z_a_rvalid), 32'd1);
    chk("nf_rd_data", z_a_rdata, 32'h1);
    z_a_req = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
